// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR block sequencing datapath.
package fir_pkg;

    localparam int unsigned FIR_DW       = 32;
    localparam int unsigned FIR_DEPTH    = 32;
    localparam int unsigned FIR_AW       = 5;
    localparam int unsigned FIR_PIPE_LAT = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage : fir_pkg

// File: rtl/fir_vld_delay.sv
// Valid-bit shift register with synchronous flush; taps the first and last stage.
module fir_vld_delay
    import fir_pkg::*;
#(
    parameter int unsigned STAGES = FIR_PIPE_LAT + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic vld_in,
    output logic vld_first,
    output logic vld_last
);

    logic [STAGES-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else if (flush) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[STAGES-2:0], vld_in};
        end
    end

    assign vld_first = pipe_q[0];
    assign vld_last  = pipe_q[STAGES-1];

endmodule : fir_vld_delay

// File: rtl/fir_block_sequencer.sv
// Feeds one block of samples from the x buffer through the FIR filter and
// captures the results into the y buffer, with start/busy/done handshake.
module fir_block_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned DW       = FIR_DW,
    parameter int unsigned DEPTH    = FIR_DEPTH,
    parameter int unsigned AW       = FIR_AW,
    parameter int unsigned PIPE_LAT = FIR_PIPE_LAT
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          data_valid_o,
    output logic          xbuf_rd_en_o,
    output logic [AW-1:0] xbuf_rd_addr_o,
    input  logic [DW-1:0] xbuf_rd_data_i,
    output logic [DW-1:0] fir_in_o,
    input  logic [DW-1:0] fir_out_i,
    output logic          ybuf_wr_en_o,
    output logic [AW-1:0] ybuf_wr_addr_o,
    output logic [DW-1:0] ybuf_wr_data_o
);

    localparam int unsigned    LW      = AW + 1;
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);

    seq_state_t    state_q, state_d;
    logic [LW-1:0] len_q, len_d, eff_len_c;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] last_idx_c;
    logic          rd_en_d, busy_d, done_d, dv_d;
    logic          flush_c;
    logic          in_vld, wr_en;

    // Zero and oversized lengths both mean a full buffer.
    assign eff_len_c  = (len_i == '0 || len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign last_idx_c = AW'(len_q - LW'(1));

    fir_vld_delay #(
        .STAGES (PIPE_LAT + 1)
    ) u_vld_delay (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (flush_c),
        .vld_in    (xbuf_rd_en_o),
        .vld_first (in_vld),
        .vld_last  (wr_en)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_en_d  = 1'b0;
        dv_d     = data_valid_o;
        flush_c  = 1'b0;

        if (wr_en && wr_cnt_q != last_idx_c) begin
            wr_cnt_d = wr_cnt_q + AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    len_d    = eff_len_c;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    rd_en_d  = 1'b1;
                    dv_d     = 1'b0;
                    state_d  = ST_FEED;
                end
            end
            ST_FEED: begin
                if (abort_i) begin
                    flush_c  = 1'b1;
                    wr_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else if (rd_cnt_q == last_idx_c) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                    rd_en_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    flush_c  = 1'b1;
                    wr_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else if (wr_en && wr_cnt_q == last_idx_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                dv_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            xbuf_rd_en_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            data_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            xbuf_rd_en_o <= rd_en_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            data_valid_o <= dv_d;
        end
    end

    // Zero samples flush the filter once the block has been read out.
    assign fir_in_o       = in_vld ? xbuf_rd_data_i : '0;
    assign xbuf_rd_addr_o = rd_cnt_q;
    assign ybuf_wr_en_o   = wr_en;
    assign ybuf_wr_addr_o = wr_cnt_q;
    assign ybuf_wr_data_o = wr_en ? fir_out_i : '0;

endmodule : fir_block_sequencer

// File: tb/tb_fir_block_sequencer.sv
// Directed bench for fir_block_sequencer with a scoreboard of expected ybuf writes.
module tb_fir_block_sequencer;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int DEPTH    = 32;
    localparam int PIPE_LAT = 9;

    logic          wb_clk_i;
    logic          wb_rst_i;
    logic          start_i;
    logic          abort_i;
    logic [AW:0]   len_i;
    logic          busy_o;
    logic          done_o;
    logic          data_valid_o;
    logic          xbuf_rd_en_o;
    logic [AW-1:0] xbuf_rd_addr_o;
    logic [DW-1:0] xbuf_rd_data_i;
    logic [DW-1:0] fir_in_o;
    logic [DW-1:0] fir_out_i;
    logic          ybuf_wr_en_o;
    logic [AW-1:0] ybuf_wr_addr_o;
    logic [DW-1:0] ybuf_wr_data_o;

    fir_block_sequencer dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .len_i          (len_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .data_valid_o   (data_valid_o),
        .xbuf_rd_en_o   (xbuf_rd_en_o),
        .xbuf_rd_addr_o (xbuf_rd_addr_o),
        .xbuf_rd_data_i (xbuf_rd_data_i),
        .fir_in_o       (fir_in_o),
        .fir_out_i      (fir_out_i),
        .ybuf_wr_en_o   (ybuf_wr_en_o),
        .ybuf_wr_addr_o (ybuf_wr_addr_o),
        .ybuf_wr_data_o (ybuf_wr_data_o)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          done_q[$];
    exp_t        mon_e;
    logic [DW-1:0] xbuf [DEPTH];
    logic [DW-1:0] filt_pipe [PIPE_LAT];
    logic        rd_en_d1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Synchronous x RAM and a pure-delay stand-in for the FIR filter.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            xbuf_rd_data_i <= '0;
            rd_en_d1       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) filt_pipe[i] <= '0;
        end else begin
            if (xbuf_rd_en_o) xbuf_rd_data_i <= xbuf[xbuf_rd_addr_o];
            rd_en_d1     <= xbuf_rd_en_o;
            filt_pipe[0] <= fir_in_o;
            for (int i = 1; i < PIPE_LAT; i++) filt_pipe[i] <= filt_pipe[i-1];
        end
    end
    assign fir_out_i = filt_pipe[PIPE_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: every ybuf write and done pulse must match the scoreboard.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (ybuf_wr_en_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'(ybuf_wr_addr_o), 64'hFFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(ybuf_wr_addr_o), 64'(mon_e.addr));
                    chk("wr_data", 64'(ybuf_wr_data_o), 64'(mon_e.data));
                    chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
                else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
            if (!rd_en_d1) chk("fir_in_zero", 64'(fir_in_o), 64'(0));
        end
    end

    // Cycle n after the start edge is seen at the negedge with cyc == c + n.
    task automatic push_exp(input int c, input int len);
        for (int k = 0; k < len; k++) sb.push_back('{k, xbuf[k], c + 2 + k + PIPE_LAT});
        done_q.push_back(c + 2 + len + PIPE_LAT);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (!done_o) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_block(input logic [AW:0] len_v, input int len);
        int c;
        start_i = 1'b1;
        len_i   = len_v;
        c       = cyc;
        push_exp(c, len);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk("c1_busy", 64'(busy_o), 64'(1));
        chk("c1_rd_en", 64'(xbuf_rd_en_o), 64'(1));
        chk("c1_rd_addr", 64'(xbuf_rd_addr_o), 64'(0));
        chk("c1_dv", 64'(data_valid_o), 64'(0));
        wait_done();
        chk("done_busy", 64'(busy_o), 64'(0));
        @(negedge wb_clk_i);
        chk("dv_after", 64'(data_valid_o), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int c;
        wb_rst_i = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        len_i    = '0;
        for (int k = 0; k < DEPTH; k++) xbuf[k] = DW'(k + 1);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_dv", 64'(data_valid_o), 64'(0));
        chk("rst_rd_en", 64'(xbuf_rd_en_o), 64'(0));
        chk("rst_wr_en", 64'(ybuf_wr_en_o), 64'(0));

        // Reset asserted between edges in the middle of FEED.
        start_i = 1'b1;
        len_i   = 6'd32;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("amid_busy", 64'(busy_o), 64'(0));
        chk("amid_rd_en", 64'(xbuf_rd_en_o), 64'(0));
        chk("amid_rd_addr", 64'(xbuf_rd_addr_o), 64'(0));
        chk("amid_fir_in", 64'(fir_in_o), 64'(0));
        chk("amid_wr_en", 64'(ybuf_wr_en_o), 64'(0));
        chk("amid_wr_addr", 64'(ybuf_wr_addr_o), 64'(0));
        chk("amid_wr_data", 64'(ybuf_wr_data_o), 64'(0));
        chk("amid_done_dv", 64'({done_o, data_valid_o}), 64'(0));
        sb.delete();
        done_q.delete();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (30) @(negedge wb_clk_i);
        chk("post_rst_idle", 64'(busy_o), 64'(0));

        // Full, zero, oversized and single-sample lengths.
        run_block(6'd32, 32);
        run_block(6'd0, 32);
        run_block(6'd40, 32);
        run_block(6'd1, 1);

        // Abort in cycle 15: writes for samples 0..4 land, nothing after.
        start_i = 1'b1;
        len_i   = 6'd32;
        c       = cyc;
        push_exp(c, 32);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        while (cyc < c + 15) @(negedge wb_clk_i);
        abort_i = 1'b1;
        while (sb.size() > 0 && sb[$].cyc > c + 15) void'(sb.pop_back());
        done_q.delete();
        @(negedge wb_clk_i);
        abort_i = 1'b0;
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_wr_en", 64'(ybuf_wr_en_o), 64'(0));
        chk("abort_dv", 64'(data_valid_o), 64'(0));
        repeat (40) @(negedge wb_clk_i);
        chk("abort_dv_late", 64'(data_valid_o), 64'(0));
        chk("abort_sb", 64'(sb.size()), 64'(0));

        // start_i held high for the whole block must not queue a second one.
        for (int k = 0; k < DEPTH; k++) xbuf[k] = DW'(32'hA000 + k * 3);
        start_i = 1'b1;
        len_i   = 6'd4;
        c       = cyc;
        push_exp(c, 4);
        @(negedge wb_clk_i);
        wait_done();
        start_i = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        chk("hold_idle", 64'(busy_o), 64'(0));
        chk("hold_dv", 64'(data_valid_o), 64'(1));
        chk("hold_sb", 64'(sb.size()), 64'(0));

        // Simultaneous start and abort in IDLE: abort wins.
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("sa_busy", 64'(busy_o), 64'(0));
        chk("sa_rd_en", 64'(xbuf_rd_en_o), 64'(0));
        chk("sa_dv", 64'(data_valid_o), 64'(1));
        repeat (20) @(negedge wb_clk_i);
        chk("sa_idle", 64'(busy_o), 64'(0));

        // Back-to-back: second start in the cycle right after done_o.
        for (int k = 0; k < DEPTH; k++) xbuf[k] = DW'(100 + k * 7);
        run_block(6'd3, 3);
        run_block(6'd5, 5);
        repeat (5) @(negedge wb_clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fir_block_sequencer

// File: doc/fir_block_sequencer.md
Name: fir_block_sequencer

Overview:
Sequences one block of samples from the FIR input sample buffer through the FIR_filter datapath and captures the filtered results into the output buffer. It replaces ad-hoc free-running index counters with an explicit start/busy/done handshake, a programmable block length and a pipeline-latency-aware capture window. It sits between the Wishbone register file (start, length, status) and the x/y sample RAMs plus the FIR_filter instance.

Parameters:
DW, 32, sample width of buffers and filter ports
DEPTH, 32, buffer depth in samples
AW, 5, buffer address width (log2 DEPTH)
PIPE_LAT, 9, cycles from a sample on fir_in_o to its result on fir_out_i (range 1..31)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  begin a block; sampled only in IDLE
abort_i  in  1  cancel the block in progress
len_i  in  AW+1  block length; 0 means DEPTH; values above DEPTH clamp to DEPTH
busy_o  out  1  high from the first FEED cycle through the last ybuf write
done_o  out  1  one-cycle pulse after the last ybuf write
data_valid_o  out  1  output buffer holds a complete block
xbuf_rd_en_o  out  1  input buffer read strobe
xbuf_rd_addr_o  out  AW  input buffer read address
xbuf_rd_data_i  in  DW  input buffer data, valid one cycle after rd_en
fir_in_o  out  DW  sample to FIR_filter
fir_out_i  in  DW  result from FIR_filter
ybuf_wr_en_o  out  1  output buffer write strobe
ybuf_wr_addr_o  out  AW  output buffer write address
ybuf_wr_data_o  out  DW  output buffer write data (= fir_out_i)

Behaviour:
- Reset (async): state IDLE; all outputs 0; all counters 0; data_valid_o 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: if start_i && !abort_i: latch L = effective length, clear data_valid_o, go to FEED. Otherwise stay.
- FEED (L cycles): xbuf_rd_en_o=1, xbuf_rd_addr_o = rd_cnt, rd_cnt 0..L-1; after rd_cnt=L-1 go to DRAIN.
- in_vld is rd_en delayed 1 cycle. fir_in_o = in_vld ? xbuf_rd_data_i : 0, so zeros flush the filter once the block ends.
- Capture: the in_vld delay line extended by PIPE_LAT cycles drives ybuf_wr_en_o. wr_cnt starts at 0 and increments per write. ybuf_wr_addr_o = wr_cnt, ybuf_wr_data_o = fir_out_i.
- DRAIN: stay until the write with wr_cnt=L-1 occurs, then go to DONE.
- DONE (1 cycle): done_o=1, data_valid_o<=1, return to IDLE.
- Timing, with start seen at edge E0 and cycles numbered after it:
  - FEED reads occur in cycles 1..L.
  - Sample k reaches the filter in cycle 2+k.
  - Its result is written in cycle 2+k+PIPE_LAT.
  - The last write is in cycle 1+L+PIPE_LAT; done_o is in cycle 2+L+PIPE_LAT.
- busy_o = state in {FEED, DRAIN}.
- start_i outside IDLE is ignored and not queued.
- abort_i in FEED/DRAIN: next cycle IDLE. The capture pipeline is flushed, so no further ybuf writes occur. No done_o; data_valid_o stays 0.
- abort_i with start_i in IDLE: abort wins and the block does not start.
- Counters never wrap: rd_cnt and wr_cnt stop at L-1. Addresses are always < DEPTH.

Decomposition:
- Shared package fir_pkg: DW, DEPTH, AW, PIPE_LAT defaults, state encoding enum (IDLE/FEED/DRAIN/DONE).
- One natural sub-module: fir_vld_delay, a parameterised PIPE_LAT+1 stage shift register of the valid bit with synchronous flush. It is reused by any future datapath controller.

Test Plan:
1. Reset mid-FEED (wb_rst_i pulsed asynchronously between edges) -> all outputs 0 immediately; state IDLE; no ybuf write after release.
2. len_i=32, xbuf[k]=k+1, model filter = PIPE_LAT=9 delay -> ybuf written addr 0..31 with data 1..32, first write cycle 11, done_o in cycle 43, data_valid_o=1 after.
3. len_i=0 -> behaves as len 32. len_i=40 -> clamped to 32. len_i=1 -> exactly one write at addr 0, cycle 11; done_o cycle 12.
4. abort_i asserted in cycle 15 of a len=32 block -> IDLE next cycle; ybuf_wr_en_o never high afterwards; no done_o; data_valid_o=0.
5. start_i held high during busy, and start_i with abort_i in IDLE -> only one block runs; the simultaneous case does not start.
6. Back-to-back: start_i in the cycle after done_o -> second block starts, data_valid_o clears on that start; fir_in_o=0 in every cycle without in_vld.
